branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- EX-stage consumer of the branch predictor's ID-stage prediction.
- Registers each conditional branch's prediction, resolves the real outcome from the register operands, and returns the training pair (we, jmp_from_ex) to the predictor.
- On a misprediction it drives a redirect address and a multi-cycle flush to the fetch/decode stages.
- Keeps saturating branch and mispredict counters for performance analysis.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a mispredict (1..7).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  pipeline stall; holds the ID->EX register
- id_valid  input  1  ID stage carries a valid instruction
- id_alu_op  input  6  decoded op (BEQ=001011, BLT=001100, BGE=001101, JAL=001110)
- id_pc  input  32  instruction address in ID
- id_imm  input  32  branch offset
- id_pred_taken  input  1  predictor decision (jmp) for this instruction
- ex_rs1  input  32  forwarded operand 1, valid in EX
- ex_rs2  input  32  forwarded operand 2, valid in EX
- upd_we  output  1  predictor training strobe (predictor "we")
- upd_taken  output  1  actual outcome (predictor "jmp_from_ex")
- mispredict  output  1  one-cycle pulse on a wrong prediction
- redirect_addr  output  32  corrected fetch address, valid with mispredict
- flush  output  1  kill the younger IF/ID instructions
- branch_cnt  output  CNT_W  resolved conditional branches
- mispred_cnt  output  CNT_W  mispredicted conditional branches

Behaviour:
- Reset: every output is 0; the ID->EX register is invalid; FSM is IDLE; counters are 0. Reset is asynchronous and may occur mid-flush, which aborts the flush immediately.
- ID->EX register:
  - Captures valid, op, pc, imm and pred on each clk when stall=0.
  - Holds its contents when stall=1.
  - Captures valid=0 whenever flush=1 (the killed ID instruction is dropped).
- EX resolve, combinational from the register and ex_rs*:
  - BEQ: taken = rs1 == rs2.
  - BLT: taken = signed rs1 < rs2.
  - BGE: taken = signed rs1 >= rs2.
  - target = pc + imm; fallthrough = pc + 4. Both wrap mod 2^32 and no overflow is flagged.
- Outputs are registered, so they appear 1 cycle after the branch occupies EX. All are 0-valued pulses unless stated.
  - upd_we = 1 for one cycle per valid conditional branch in EX with stall=0.
  - upd_taken = resolved taken for that branch; it is 0 whenever upd_we = 0.
  - mispredict = 1 when a valid conditional branch has taken != pred.
  - redirect_addr = target if taken, else fallthrough. It holds its last value otherwise.
  - JAL and non-branch ops: no update, no mispredict (JAL is always predicted taken).
  - A branch held in EX under stall is resolved exactly once, on the cycle stall deasserts.
- FSM states:
  - IDLE -> FLUSH on mispredict, loading a counter with FLUSH_CYCLES.
  - FLUSH: flush=1; the counter decrements each cycle; goes to IDLE when it reaches 1.
  - In FLUSH the EX entry is invalid, so no new resolves occur. A mispredict cannot arrive during FLUSH; if one does, the counter reloads.
  - flush asserts on the same registered edge as mispredict.
- Counters:
  - branch_cnt increments with upd_we; mispred_cnt increments with mispredict.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Shared package cpu_pkg: alu_op localparams (BEQ, BLT, BGE, JAL), the 2-bit FSM state encoding, and XLEN=32. The predictor uses the same package.
- One natural sub-module: sat_counter (CNT_W, inc, value), instantiated twice.

Test Plan:
- BEQ at pc=0x100, imm=0x20, rs1=rs2=5, pred=0 -> upd_we=1, upd_taken=1, mispredict=1, redirect_addr=0x120, flush high for 2 cycles, mispred_cnt=1.
- BLT at pc=0x200, rs1=0xFFFFFFFF (-1), rs2=1, pred=1 -> taken, no mispredict, no flush, branch_cnt=1.
- BGE at pc=0x300, rs1=1, rs2=2, pred=1 -> not taken, mispredict, redirect_addr=0x304; the ID instruction during flush produces no upd_we.
- JAL with pred=1, then ADD -> upd_we stays 0, counters unchanged.
- BEQ held in EX with stall=1 for 3 cycles -> exactly one upd_we pulse, issued 1 cycle after stall drops.
- rst_n low during the 2nd flush cycle -> flush=0 immediately, counters=0; the next branch resolves normally.
- Force mispred_cnt to 0xFFFFFFFF, then one more mispredict -> count stays 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: datapath width, ALU op codes of the
//                control-flow instructions, flush FSM state encoding and a
//                helper that classifies conditional branches.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_BEQ = 6'b001011;
    localparam logic [5:0] OP_BLT = 6'b001100;
    localparam logic [5:0] OP_BGE = 6'b001101;
    localparam logic [5:0] OP_JAL = 6'b001110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLUSH = 2'b01
    } flush_state_e;

    // JAL is unconditional and always predicted taken, so it never trains
    // the predictor; only the three compare-and-branch ops do.
    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_if
//  Description : Bundle between the ID/EX pipeline and the branch resolver:
//                ID-stage instruction fields, EX operands, predictor training
//                pair, redirect/flush and the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_if #(
    parameter int CNT_W = 32
);
    import cpu_pkg::*;

    logic             stall;
    logic             id_valid;
    logic [5:0]       id_alu_op;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_imm;
    logic             id_pred_taken;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic             upd_we;
    logic             upd_taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_addr;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // Pipeline side: supplies instructions/operands, consumes results.
    modport master (
        output stall, id_valid, id_alu_op, id_pc, id_imm, id_pred_taken,
               ex_rs1, ex_rs2,
        input  upd_we, upd_taken, mispredict, redirect_addr, flush,
               branch_cnt, mispred_cnt
    );

    // Resolver side.
    modport slave (
        input  stall, id_valid, id_alu_op, id_pc, id_imm, id_pred_taken,
               ex_rs1, ex_rs2,
        output upd_we, upd_taken, mispredict, redirect_addr, flush,
               branch_cnt, mispred_cnt
    );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] value
);

    // Count up on inc, holding once every bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : EX-stage branch resolver. Registers the ID-stage prediction,
//                resolves BEQ/BLT/BGE from the forwarded operands, trains the
//                predictor, and on a misprediction issues a redirect plus a
//                FLUSH_CYCLES-long flush. Keeps saturating perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    branch_resolve_if.slave bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    // ID->EX register
    logic            r_ex_valid;
    logic [5:0]      r_ex_op;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_imm;
    logic            r_ex_pred;

    // EX resolve
    logic            w_is_cond;
    logic            w_taken;
    logic            w_resolve;
    logic            w_mispredict;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fallthrough;
    logic [XLEN-1:0] w_redirect;

    // Registered outputs
    logic            r_upd_we;
    logic            r_upd_taken;
    logic            r_mispredict;
    logic [XLEN-1:0] r_redirect;

    // Flush FSM
    flush_state_e    r_state;
    flush_state_e    w_state_nxt;
    logic [2:0]      r_flush_cnt;
    logic [2:0]      w_flush_cnt_nxt;
    logic            w_flush;

    logic [CNT_W-1:0] w_branch_cnt;
    logic [CNT_W-1:0] w_mispred_cnt;

    assign w_flush = (r_state == ST_FLUSH);

    // ID->EX capture. The instruction behind a mispredicting branch is
    // already wrong-path, so it is dropped on the same edge the flush starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_pc    <= '0;
            r_ex_imm   <= '0;
            r_ex_pred  <= 1'b0;
        end else if (w_flush || w_mispredict) begin
            r_ex_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_ex_valid <= bus.id_valid;
            r_ex_op    <= bus.id_alu_op;
            r_ex_pc    <= bus.id_pc;
            r_ex_imm   <= bus.id_imm;
            r_ex_pred  <= bus.id_pred_taken;
        end
    end

    // Branch outcome and candidate fetch addresses for the entry in EX.
    always_comb begin
        w_is_cond     = is_cond_branch(r_ex_op);
        w_taken       = 1'b0;
        w_target      = r_ex_pc + r_ex_imm;
        w_fallthrough = r_ex_pc + 32'd4;
        case (r_ex_op)
            OP_BEQ:  w_taken = (bus.ex_rs1 == bus.ex_rs2);
            OP_BLT:  w_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            OP_BGE:  w_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            default: w_taken = 1'b0;
        endcase
        // Resolution waits for stall to drop so a held branch fires once.
        w_resolve    = r_ex_valid && w_is_cond && !bus.stall;
        w_mispredict = w_resolve && (w_taken != r_ex_pred);
        w_redirect   = w_taken ? w_target : w_fallthrough;
    end

    // Register the training pair, mispredict pulse and redirect address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_we     <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
            r_redirect   <= '0;
        end else begin
            r_upd_we     <= w_resolve;
            r_upd_taken  <= w_resolve && w_taken;
            r_mispredict <= w_mispredict;
            if (w_resolve) begin
                r_redirect <= w_redirect;
            end
        end
    end

    // Flush FSM state and down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Flush FSM next state: enter on mispredict, leave when the count is 1.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (w_mispredict) begin
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt     = ST_IDLE;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // Counters advance on the same edge the upd_we / mispredict pulses rise.
    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_resolve),
        .value (w_branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_mispredict),
        .value (w_mispred_cnt)
    );

    assign bus.upd_we        = r_upd_we;
    assign bus.upd_taken     = r_upd_taken;
    assign bus.mispredict    = r_mispredict;
    assign bus.redirect_addr = r_redirect;
    assign bus.flush         = w_flush;
    assign bus.branch_cnt    = w_branch_cnt;
    assign bus.mispred_cnt   = w_mispred_cnt;

endmodule
`default_nettype wire
